// File: rtl/dumper.sv
// -----------------------------------------------------------------------------
// dumper
//
// Replays the contents of a RAM block, address 0 up to a latched last address
// (inclusive), as a parallel byte stream.  Each emitted byte appears on dataOut
// with a one-cycle newData strobe.  It is the read-back counterpart of the byte
// loader and sits between the RAM read port and a byte sink such as a UART
// transmitter.
//
// Per byte the FSM steps RD -> CAP -> SEND:
//   RD   : read_rq is high for this one cycle with addrOut on the address bus
//   CAP  : the registered RAM presents ramData, which is captured into dataOut
//   SEND : wait for ready, strobe newData, then advance or finish
// With ready held high this gives one byte every 3 cycles.  The first newData
// appears 3 cycles after the edge that accepts start.
//
// Ports
//   clk       in   1         system clock, all logic on posedge
//   reset     in   1         asynchronous active-low reset
//   start     in   1         begins a dump; sampled only while idle
//   lastAddr  in   addrSize  last address to dump (inclusive), latched at start
//   ready     in   1         sink can accept a byte this cycle
//   ramData   in   8         RAM read data, valid one cycle after read_rq
//   read_rq   out  1         RAM read request for addrOut
//   addrOut   out  addrSize  RAM read address
//   dataOut   out  8         byte presented to the sink, held between bytes
//   newData   out  1         one-cycle strobe: dataOut holds a new byte
//   busy      out  1         high from start acceptance until done
//   done      out  1         one-cycle pulse when the dump completes
//
// Configuration macro
//   DUMPER_STOP_ON_ZERO_EN : when defined, a 8'h00 byte read in CAP ends the
//   dump at once.  That byte is captured into dataOut but never strobed.
//   When undefined, zero bytes are emitted like any other byte.
// -----------------------------------------------------------------------------
module dumper #(
   parameter int addrSize = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [addrSize-1:0] lastAddr,
   input  logic                ready,
   input  logic [7:0]          ramData,
   output logic                read_rq,
   output logic [addrSize-1:0] addrOut,
   output logic [7:0]          dataOut,
   output logic                newData,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_SEND = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic [addrSize-1:0] ADDR_ZERO = {addrSize{1'b0}};
   localparam logic [addrSize-1:0] ADDR_ONE  = {{(addrSize-1){1'b0}}, 1'b1};

   state_t              state_q,   state_d;
   logic [addrSize-1:0] addr_q,    addr_d;
   logic [addrSize-1:0] last_q,    last_d;
   logic [7:0]          data_q,    data_d;
   logic                read_rq_q, read_rq_d;
   logic                new_q,     new_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;

   // Next-state and next-output logic; every output is registered, so the
   // value computed here for a transition is what is seen in the next state.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      last_d    = last_q;
      data_d    = data_q;
      read_rq_d = 1'b0;
      new_d     = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               last_d    = lastAddr;
               addr_d    = ADDR_ZERO;
               busy_d    = 1'b1;
               read_rq_d = 1'b1;   // asserted for the whole RD cycle
               state_d   = S_RD;
            end else begin
               state_d   = S_IDLE;
            end
         end

         S_RD: begin
            state_d = S_CAP;
         end

         S_CAP: begin
            data_d = ramData;
`ifdef DUMPER_STOP_ON_ZERO_EN
            if (ramData == 8'h00) begin
               state_d = S_FIN;    // terminator: captured but never strobed
            end else begin
               state_d = S_SEND;
            end
`else
            state_d = S_SEND;
`endif
         end

         S_SEND: begin
            if (ready) begin
               new_d = 1'b1;
               // Compare before incrementing so a full-RAM dump never wraps.
               if (addr_q == last_q) begin
                  state_d = S_FIN;
               end else begin
                  addr_d    = addr_q + ADDR_ONE;
                  read_rq_d = 1'b1;
                  state_d   = S_RD;
               end
            end else begin
               state_d = S_SEND;
            end
         end

         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= ADDR_ZERO;
         last_q    <= ADDR_ZERO;
         data_q    <= 8'h00;
         read_rq_q <= 1'b0;
         new_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         last_q    <= last_d;
         data_q    <= data_d;
         read_rq_q <= read_rq_d;
         new_q     <= new_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign read_rq = read_rq_q;
   assign addrOut = addr_q;
   assign dataOut = data_q;
   assign newData = new_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_dumper.sv
module tb_dumper;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] lastAddr;
   logic          ready;
   logic [7:0]    ramData;
   logic          read_rq;
   logic [AW-1:0] addrOut;
   logic [7:0]    dataOut;
   logic          newData;
   logic          busy;
   logic          done;

   dumper #(.addrSize(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .lastAddr(lastAddr),
      .ready(ready), .ramData(ramData), .read_rq(read_rq), .addrOut(addrOut),
      .dataOut(dataOut), .newData(newData), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Registered-read RAM model, one cycle of latency.
   logic [7:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (read_rq) ramData <= mem[addrOut];
   end

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];
   int         obs_t [$];
   int         done_t;
   logic       done_busy;
   logic [AW-1:0] done_addr;
   logic [7:0] done_data;

   // Issue a one-cycle start pulse with the given last address.
   task automatic kick(input logic [AW-1:0] la);
      @(negedge clk);
      lastAddr = la;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Record strobes (value and cycle) until done or the cycle budget runs out.
   // t counts negedges after the start pulse; poke_t re-pulses start and
   // changes lastAddr to 1 mid-dump.
   task automatic run_until_done(input int max_cyc, input int poke_t);
      obs_q.delete();
      obs_t.delete();
      done_t = -1;
      for (int t = 1; t <= max_cyc; t++) begin
         @(negedge clk);
         if (t == poke_t) begin
            start    = 1'b1;
            lastAddr = 9'd1;
         end
         if (t == poke_t + 1) start = 1'b0;
         if (newData) begin
            obs_q.push_back(dataOut);
            obs_t.push_back(t);
         end
         if (done) begin
            done_t    = t;
            done_busy = busy;
            done_addr = addrOut;
            done_data = dataOut;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; ready = 1'b1; lastAddr = '0;
      #12;
      checks++;
      if ({read_rq, addrOut, dataOut, newData, busy, done} !== 21'd0)
         $display("FAIL reset_outputs got=%h exp=0",
                  {read_rq, addrOut, dataOut, newData, busy, done});
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, newData, done, read_rq} !== 4'b0000)
         $display("FAIL idle_after_reset got=%b exp=0000", {busy, newData, done, read_rq});
      if ({busy, newData, done, read_rq} !== 4'b0000) failures++;
      if ({read_rq, addrOut, dataOut, newData, busy, done} !== 21'd0) failures++;
   endtask

   task automatic test_basic;
      mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;
      for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
      kick(9'd3);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
      run_until_done(60, -1);
      checks++;
      if (obs_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", obs_q.size()); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== e || obs_t[i] != 3 + 3 * i) begin
            failures++;
            $display("FAIL basic_byte%0d got=%h@%0d exp=%h@%0d", i,
                     (i < obs_q.size()) ? obs_q[i] : 8'hxx,
                     (i < obs_t.size()) ? obs_t[i] : -1, e, 3 + 3 * i);
         end
      end
      checks++;
      if (done_t != 13 || done_busy !== 1'b0 || done_addr !== 9'd3) begin
         failures++;
         $display("FAIL basic_done got=t%0d busy%b addr%0d exp=t13 busy0 addr3",
                  done_t, done_busy, done_addr);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || addrOut !== 9'd3 || dataOut !== 8'h44) begin
         failures++;
         $display("FAIL basic_after got=done%b addr%0d data%h exp=done0 addr3 data44",
                  done, addrOut, dataOut);
      end
   endtask

   task automatic test_single;
      mem[0] = 8'h5A;
      exp_q.push_back(8'h5A);
      kick(9'd0);
      run_until_done(30, -1);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_t[0] != 3) begin
         failures++;
         $display("FAIL single_byte got=n%0d exp=one 5a at 3", obs_q.size());
      end
      void'(exp_q.pop_front());
      checks++;
      if (done_t != 4 || done_addr !== 9'd0) begin
         failures++;
         $display("FAIL single_done got=t%0d addr%0d exp=t4 addr0", done_t, done_addr);
      end
   endtask

   task automatic test_backpressure;
      int bad;
      mem[0] = 8'hA5; mem[1] = 8'h3C;
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      ready = 1'b0;
      kick(9'd1);
      bad = 0;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         if (newData !== 1'b0) bad++;
         if (t >= 2 && dataOut !== 8'hA5) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
      ready = 1'b1;
      run_until_done(30, -1);
      checks++;
      if (obs_q.size() != 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", obs_q.size()); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== e) begin
            failures++;
            $display("FAIL stall_byte%0d got=%h exp=%h", i,
                     (i < obs_q.size()) ? obs_q[i] : 8'hxx, e);
         end
      end
      checks++;
      if (done_t != 5 || obs_t.size() < 1 || obs_t[0] != 1) begin
         failures++;
         $display("FAIL stall_timing got=done t%0d exp=t5 first strobe t1", done_t);
      end
   endtask

   task automatic test_abort;
      int waited, done_seen;
      mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;
      kick(9'd3);
      waited = 0;
      while (addrOut !== 9'd2 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (addrOut !== 9'd2) begin failures++; $display("FAIL abort_reach got=%0d exp=2", addrOut); end
      reset = 1'b0;
      #1;
      checks++;
      if ({read_rq, addrOut, dataOut, newData, busy, done} !== 21'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%h exp=0",
                  {read_rq, addrOut, dataOut, newData, busy, done});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      done_seen = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1 || newData === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", done_seen); end
      exp_q.push_back(8'h41); exp_q.push_back(8'h42);
      kick(9'd1);
      run_until_done(30, -1);
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || obs_t[0] != 3) begin
         failures++;
         $display("FAIL abort_restart got=n%0d exp=41,42 from t3", obs_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_ignore;
      for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
      kick(9'd3);
      run_until_done(60, 4);
      checks++;
      if (obs_q.size() != 4 || done_addr !== 9'd3 || done_t != 13) begin
         failures++;
         $display("FAIL ignore_midstart got=n%0d addr%0d t%0d exp=n4 addr3 t13",
                  obs_q.size(), done_addr, done_t);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== e) begin
            failures++;
            $display("FAIL ignore_byte%0d got=%h exp=%h", i,
                     (i < obs_q.size()) ? obs_q[i] : 8'hxx, e);
         end
      end
   endtask

   task automatic test_zero;
      int exp_done;
      logic [7:0] exp_last;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h33;
`ifdef DUMPER_STOP_ON_ZERO_EN
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_done = 9; exp_last = 8'h00;
`else
      for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
      exp_done = 13; exp_last = 8'h33;
`endif
      kick(9'd3);
      run_until_done(60, -1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL zero_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== e) begin
            failures++;
            $display("FAIL zero_byte%0d got=%h exp=%h", i,
                     (i < obs_q.size()) ? obs_q[i] : 8'hxx, e);
         end
      end
      checks++;
      if (done_t != exp_done || done_data !== exp_last) begin
         failures++;
         $display("FAIL zero_done got=t%0d data%h exp=t%0d data%h",
                  done_t, done_data, exp_done, exp_last);
      end
   endtask

   task automatic test_full;
      int bad;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = 8'($urandom_range(1, 255));
         exp_q.push_back(mem[i]);
      end
      kick(9'd511);
      run_until_done(1700, -1);
      checks++;
      if (obs_q.size() != 512 || done_t != 1537 || done_addr !== 9'd511) begin
         failures++;
         $display("FAIL full_ram got=n%0d t%0d addr%0d exp=n512 t1537 addr511",
                  obs_q.size(), done_t, done_addr);
      end
      bad = 0;
      for (int i = 0; exp_q.size() > 0; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         if (i >= obs_q.size() || obs_q[i] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL full_data got=%0d wrong bytes exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_backpressure();
      test_abort();
      test_ignore();
      test_zero();
      test_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
